bullet_fire_ctrl: RTL

Upstream controller for the bullet position stage. It owns the per-bullet "in flight" flags (`bullet_display_o`), which the position stage consumes to decide whether each bullet travels upward or stays parked on the ship. It turns the player fire button into single launches, subject to a cooldown. It retires bullets on a collision hit or when they leave the top of the screen, and counts shots for the score/HUD logic.

---
 rtl/bullet_fire_ctrl_if.sv | 32 +++
 rtl/bullet_fire_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/bullet_fire_ctrl_if.sv
// rtl/bullet_fire_ctrl_if.sv - fire-controller bundle between player/position stage and bullet_fire_ctrl
interface bullet_fire_ctrl_if #(
    parameter int BulletCount = 2
);
    logic                         fire_i;
    logic                         game_active_i;
    logic [BulletCount-1:0]       hit_i;
    logic [BulletCount-1:0][9:0]  bullet_y_i;
    logic [BulletCount-1:0]       bullet_display_o;
    logic                         fire_pulse_o;
    logic [15:0]                  shots_fired_o;

    modport master (
        output fire_i,
        output game_active_i,
        output hit_i,
        output bullet_y_i,
        input  bullet_display_o,
        input  fire_pulse_o,
        input  shots_fired_o
    );

    modport slave (
        input  fire_i,
        input  game_active_i,
        input  hit_i,
        input  bullet_y_i,
        output bullet_display_o,
        output fire_pulse_o,
        output shots_fired_o
    );
endinterface

// File: rtl/bullet_fire_ctrl.sv
// rtl/bullet_fire_ctrl.sv - bullet launch/retire controller with cooldown and shot counter
// Optional BULLET_AUTOFIRE_EN: fire level (not edge) triggers launches.
module bullet_fire_ctrl #(
    parameter int BulletCount    = 2,
    parameter int CooldownFrames = 8,
    parameter int TopLimit       = 8,
    parameter int ScreenH        = 480
) (
    input  logic                     frame_clk_i,
    input  logic                     reset_i,
    bullet_fire_ctrl_if.slave        fire_if
);
    localparam int CdW = (CooldownFrames < 1) ? 1 : $clog2(CooldownFrames + 1);
    localparam logic [CdW-1:0] CdLoad = CdW'(CooldownFrames);
    localparam logic [9:0] TopY    = 10'(TopLimit);
    localparam logic [9:0] BottomY = 10'(ScreenH);

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } slot_state_t;

    slot_state_t            slot_q [BulletCount];
    logic                   fire_prev_q;
    logic                   fire_pulse_q;
    logic [15:0]            shots_q;
    logic [CdW-1:0]         cooldown_q;

    logic                   trigger;
    logic                   launch;
    logic                   found;
    logic [BulletCount-1:0] launch_sel;
    logic [BulletCount-1:0] retire;
    logic [BulletCount-1:0] display;

`ifdef BULLET_AUTOFIRE_EN
    assign trigger = fire_if.fire_i;
`else
    assign trigger = fire_if.fire_i & ~fire_prev_q;
`endif

    // Only slots already IDLE at the start of the edge are candidates, so a
    // slot retiring this frame cannot be relaunched until the next one.
    always_comb begin
        launch_sel = '0;
        found      = 1'b0;
        retire     = '0;
        display    = '0;
        for (int i = 0; i < BulletCount; i++) begin
            display[i] = (slot_q[i] == FLY);
            retire[i]  = fire_if.hit_i[i]
                       | (fire_if.bullet_y_i[i] < TopY)
                       | (fire_if.bullet_y_i[i] >= BottomY);
            if (!found && slot_q[i] == IDLE) begin
                launch_sel[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign launch = trigger & fire_if.game_active_i & (cooldown_q == '0) & found;

    always_ff @(posedge frame_clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < BulletCount; i++) begin
                slot_q[i] <= IDLE;
            end
            fire_prev_q  <= 1'b1;
            fire_pulse_q <= 1'b0;
            shots_q      <= '0;
            cooldown_q   <= '0;
        end else begin
            fire_prev_q  <= fire_if.fire_i;
            fire_pulse_q <= launch;

            if (!fire_if.game_active_i) begin
                cooldown_q <= '0;
            end else if (launch) begin
                cooldown_q <= CdLoad;
            end else if (cooldown_q != '0) begin
                cooldown_q <= cooldown_q - CdW'(1);
            end

            if (launch && shots_q != 16'hFFFF) begin
                shots_q <= shots_q + 16'd1;
            end

            for (int i = 0; i < BulletCount; i++) begin
                case (slot_q[i])
                    IDLE: if (launch && launch_sel[i]) slot_q[i] <= FLY;
                    FLY:  if (!fire_if.game_active_i || retire[i]) slot_q[i] <= IDLE;
                    default: slot_q[i] <= IDLE;
                endcase
            end
        end
    end

    assign fire_if.bullet_display_o = display;
    assign fire_if.fire_pulse_o     = fire_pulse_q;
    assign fire_if.shots_fired_o    = shots_q;
endmodule
